// File: rtl/counter_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : counter_ctrl_pkg
// Brief    : Shared state encoding and default widths for counter_ctrl.
// Revision : 1.0
// ============================================================================
package counter_ctrl_pkg;

   localparam int c_default_width  = 4;
   localparam int c_default_pcnt_w = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      DONE   = 2'd3
   } state_t;

endpackage
`default_nettype wire

// File: rtl/counter_core.sv
`default_nettype none
// ============================================================================
// Module   : counter_core
// Brief    : WIDTH-bit up counter with synchronous clear, enable and wrap.
// Revision : 1.0
// ============================================================================
module counter_core
   import counter_ctrl_pkg::*;
#(
   parameter int WIDTH = c_default_width
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic [WIDTH-1:0] limit,
   output logic [WIDTH-1:0] count,
   output logic             at_limit
);

   assign at_limit = (count == limit);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         count <= '0;
      end else if (enable) begin
         count <= at_limit ? '0 : count + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : counter_ctrl
// Brief    : One-shot / periodic counter controller with pause, abort and
//            saturating period counter.
// Revision : 1.0
// ============================================================================
module counter_ctrl
   import counter_ctrl_pkg::*;
#(
   parameter int WIDTH  = c_default_width,
   parameter int PCNT_W = c_default_pcnt_w
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              pause,
   input  logic              abort,
   input  logic              mode,
   input  logic [WIDTH-1:0]  limit,
   output logic [WIDTH-1:0]  count,
   output logic              busy,
   output logic              done,
   output logic              tc,
   output logic [PCNT_W-1:0] periods
);

   state_t             r_state;
   logic [WIDTH-1:0]   r_limit_q;
   logic               r_mode_q;
   logic               r_busy;
   logic               r_done;
   logic               r_tc;
   logic [PCNT_W-1:0]  r_periods;

   logic               w_go;
   logic               w_run;
   logic               w_clear;
   logic               w_enable;
   logic               w_at_limit;

   // One-shot terminal count holds the counter; periodic lets it wrap.
   always_comb begin
      w_go     = start && ((r_state == IDLE) || (r_state == DONE));
      w_run    = (r_state == RUN) && !pause && !abort;
      w_clear  = abort || w_go;
      w_enable = w_run && !(w_at_limit && !r_mode_q);
   end

   counter_core #(
      .WIDTH (WIDTH)
   ) u_core (
      .clk      (clk),
      .reset    (reset),
      .clear    (w_clear),
      .enable   (w_enable),
      .limit    (r_limit_q),
      .count    (count),
      .at_limit (w_at_limit)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= IDLE;
         r_limit_q <= '0;
         r_mode_q  <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_tc      <= 1'b0;
         r_periods <= '0;
      end else begin
         r_tc <= 1'b0;
         if (abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
         end else begin
            case (r_state)
               IDLE, DONE: begin
                  if (start) begin
                     r_limit_q <= limit;
                     r_mode_q  <= mode;
                     r_periods <= '0;
                     r_state   <= RUN;
                     r_busy    <= 1'b1;
                     r_done    <= 1'b0;
                  end
               end
               RUN: begin
                  if (pause) begin
                     r_state <= PAUSED;
                  end else if (w_at_limit) begin
                     r_tc <= 1'b1;
                     if (r_periods != {PCNT_W{1'b1}}) begin
                        r_periods <= r_periods + 1'b1;
                     end
                     if (!r_mode_q) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end
                  end
               end
               PAUSED: begin
                  if (!pause) begin
                     r_state <= RUN;
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign busy    = r_busy;
   assign done    = r_done;
   assign tc      = r_tc;
   assign periods = r_periods;

endmodule
`default_nettype wire

// File: tb/tb_counter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_ctrl
// Brief    : Directed scoreboard bench for counter_ctrl (WIDTH=4, PCNT_W=2).
// Revision : 1.0
// ============================================================================
module tb_counter_ctrl;

   typedef struct {
      logic [3:0] count;
      logic       busy;
      logic       done;
      logic       tc;
      logic [1:0] periods;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic       pause;
   logic       abort;
   logic       mode;
   logic [3:0] limit;
   logic [3:0] count;
   logic       busy;
   logic       done;
   logic       tc;
   logic [1:0] periods;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   counter_ctrl #(
      .WIDTH  (4),
      .PCNT_W (2)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .pause   (pause),
      .abort   (abort),
      .mode    (mode),
      .limit   (limit),
      .count   (count),
      .busy    (busy),
      .done    (done),
      .tc      (tc),
      .periods (periods)
   );

   always #5 clk = ~clk;

   // Monitor: one expected vector per rising edge, checked 1 time unit later.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         if (count !== e.count || busy !== e.busy || done !== e.done ||
             tc !== e.tc || periods !== e.periods) begin
            errors++;
            $display("FAIL chk%0d: got count=%0d busy=%b done=%b tc=%b periods=%0d, expected count=%0d busy=%b done=%b tc=%b periods=%0d",
                     checks, count, busy, done, tc, periods,
                     e.count, e.busy, e.done, e.tc, e.periods);
         end
      end
   end

   task automatic drv(input logic s, input logic pa, input logic ab,
                      input logic m, input logic [3:0] l);
      start = s;
      pause = pa;
      abort = ab;
      mode  = m;
      limit = l;
   endtask

   task automatic cyc(input logic [3:0] c, input logic b, input logic d,
                      input logic t, input logic [1:0] p);
      exp_t e;
      e.count   = c;
      e.busy    = b;
      e.done    = d;
      e.tc      = t;
      e.periods = p;
      q.push_back(e);
      @(negedge clk);
   endtask

   function automatic logic [1:0] sat(input int n);
      return (n > 3) ? 2'd3 : 2'(n);
   endfunction

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1;
      drv(0, 0, 0, 0, 4'd0);
      @(negedge clk);
      cyc(0, 0, 0, 0, 0);
      drv(1, 0, 0, 1, 4'd5);            // start held under reset is ignored
      cyc(0, 0, 0, 0, 0);
      reset = 1'b0;
      drv(0, 0, 0, 0, 4'd0);
      cyc(0, 0, 0, 0, 0);

      // Periodic, limit 5, with a mid-run start/limit/mode change ignored
      drv(1, 0, 0, 1, 4'd5);
      cyc(0, 1, 0, 0, 0);
      for (int k = 1; k <= 20; k++) begin
         if (k == 3) drv(1, 0, 0, 0, 4'd2);
         else        drv(0, 0, 0, 1, 4'd5);
         cyc(4'(k % 6), 1, 0, (k % 6 == 0), sat(k / 6));
      end
      drv(0, 0, 1, 1, 4'd5);
      cyc(0, 0, 0, 0, 3);

      // One-shot, limit 3, then restart from DONE
      for (int r = 0; r < 2; r++) begin
         drv(1, 0, 0, 0, 4'd3);
         cyc(0, 1, 0, 0, 0);
         drv(0, 0, 0, 0, 4'd3);
         for (int k = 1; k <= 3; k++) cyc(4'(k), 1, 0, 0, 0);
         cyc(3, 0, 1, 1, 1);
         cyc(3, 0, 1, 0, 1);
      end

      // Pause at count 2 for four cycles, limit 9 periodic
      drv(1, 0, 0, 1, 4'd9);
      cyc(0, 1, 0, 0, 0);
      drv(0, 0, 0, 1, 4'd9);
      cyc(1, 1, 0, 0, 0);
      cyc(2, 1, 0, 0, 0);
      drv(0, 1, 0, 1, 4'd9);
      for (int k = 0; k < 4; k++) cyc(2, 1, 0, 0, 0);
      drv(0, 0, 0, 1, 4'd9);
      cyc(2, 1, 0, 0, 0);
      cyc(3, 1, 0, 0, 0);

      // Pause exactly at terminal count, then abort+start+pause together
      for (int k = 4; k <= 9; k++) cyc(4'(k), 1, 0, 0, 0);
      drv(0, 1, 0, 1, 4'd9);
      cyc(9, 1, 0, 0, 0);
      cyc(9, 1, 0, 0, 0);
      drv(0, 0, 0, 1, 4'd9);
      cyc(9, 1, 0, 0, 0);
      cyc(0, 1, 0, 1, 1);
      drv(1, 1, 1, 1, 4'd9);
      cyc(0, 0, 0, 0, 1);
      drv(0, 0, 0, 0, 4'd0);
      cyc(0, 0, 0, 0, 1);

      // limit 0: periodic tc every cycle with saturation, then one-shot
      drv(1, 0, 0, 1, 4'd0);
      cyc(0, 1, 0, 0, 0);
      drv(0, 0, 0, 1, 4'd0);
      for (int k = 1; k <= 5; k++) cyc(0, 1, 0, 1, sat(k));
      drv(0, 0, 1, 0, 4'd0);
      cyc(0, 0, 0, 0, 3);
      drv(1, 0, 0, 0, 4'd0);
      cyc(0, 1, 0, 0, 0);
      drv(0, 0, 0, 0, 4'd0);
      cyc(0, 0, 1, 1, 1);
      cyc(0, 0, 1, 0, 1);

      // Reset mid-run at count 4 with start asserted
      drv(1, 0, 0, 1, 4'd9);
      cyc(0, 1, 0, 0, 0);
      drv(0, 0, 0, 1, 4'd9);
      for (int k = 1; k <= 4; k++) cyc(4'(k), 1, 0, 0, 0);
      reset = 1'b1;
      drv(1, 0, 0, 1, 4'd9);
      cyc(0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      reset = 1'b0;
      drv(0, 0, 0, 0, 4'd0);
      cyc(0, 0, 0, 0, 0);

      @(posedge clk);
      #2;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expected vectors left unchecked, expected 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
